// File: rtl/simplez_pkg.sv
// simplez_pkg: command/response bytes, loader states and RAM limits shared by Simplez F blocks
package simplez_pkg;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [8:0] MAX_WORDS = 9'h1F8;
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_DAT_H, S_DAT_L, S_WRITE, S_CHK, S_RESP
  } state_t;
endpackage

// File: rtl/simplez_loader_timer.sv
// simplez_loader_timer: inter-byte timeout counter, saturates and flags once TIMEOUT idle cycles pass
module simplez_loader_timer #(
  parameter int TIMEOUT = 2_400_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  logic i_restart,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign o_expired = r_cnt == CW'(TIMEOUT);
  always_ff @(posedge clk) begin
    if (!rstn || !i_en || i_restart) r_cnt <= '0;
    else if (!o_expired) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/simplez_loader.sv
// simplez_loader: serial program loader writing a checksummed image into RAM while holding the CPU in reset
module simplez_loader import simplez_pkg::*; #(
  parameter int AW = 9,
  parameter int DW = 12,
  parameter int MAX_WORDS = int'(simplez_pkg::MAX_WORDS),
  parameter int TIMEOUT = 2_400_000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_rcv,
  input  logic [7:0]    rx_data,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          cpu_rstn,
  output logic          busy
);
  localparam logic [AW-1:0] MAXW = AW'(MAX_WORDS);
  state_t r_state, w_next;
  logic [AW-9:0] r_cnt_h;
  logic [3:0] r_hi;
  logic [7:0] r_sum, r_rsp, w_rsp;
  logic [AW-1:0] r_count, r_idx, w_count, w_idx_inc;
  logic w_run, w_expired, w_bad, w_load;
  assign w_count = {r_cnt_h, rx_data};
  assign w_idx_inc = r_idx + AW'(1);
  assign w_bad = w_count == '0 || w_count > MAXW;
  assign w_run = r_state != S_IDLE && r_state != S_RESP;
  assign w_load = r_state == S_IDLE && rx_rcv && rx_data == CMD_LOAD;
  simplez_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rstn(rstn), .i_en(w_run), .i_restart(rx_rcv), .o_expired(w_expired)
  );
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_rsp = r_rsp;
    case (r_state)
      S_IDLE:  w_next = w_load ? S_CNT_H : S_IDLE;
      S_CNT_H: w_next = rx_rcv ? S_CNT_L : S_CNT_H;
      S_CNT_L: if (rx_rcv) begin
        w_next = w_bad ? S_RESP : S_DAT_H;
        w_rsp = RSP_ERR;
      end
      S_DAT_H: w_next = rx_rcv ? S_DAT_L : S_DAT_H;
      S_DAT_L: w_next = rx_rcv ? S_WRITE : S_DAT_L;
      S_WRITE: w_next = w_idx_inc == r_count ? S_CHK : S_DAT_H;
      S_CHK:   if (rx_rcv) begin
        w_next = S_RESP;
        w_rsp = rx_data == r_sum ? RSP_OK : RSP_ERR;
      end
      S_RESP:  w_next = tx_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
    // a byte arriving in the same cycle as expiry still counts as on time
    if (w_run && r_state != S_WRITE && !rx_rcv && w_expired) begin
      w_next = S_RESP;
      w_rsp = RSP_ERR;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_start <= 1'b0;
      tx_data <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      cpu_rstn <= 1'b1;
      busy <= 1'b0;
      r_cnt_h <= '0;
      r_hi <= '0;
      r_sum <= '0;
      r_count <= '0;
      r_idx <= '0;
      r_rsp <= '0;
    end else begin
      r_rsp <= w_rsp;
      busy <= w_next != S_IDLE;
      tx_start <= r_state == S_RESP && tx_ready;
      mem_we <= r_state == S_DAT_L && rx_rcv;
      if (r_state == S_RESP && tx_ready) tx_data <= r_rsp;
      if (w_load) begin
        r_idx <= '0;
        r_sum <= '0;
        cpu_rstn <= 1'b0;
      end else if (tx_start && tx_data == RSP_OK) cpu_rstn <= 1'b1;
      if (rx_rcv && r_state == S_CNT_H) r_cnt_h <= rx_data[AW-9:0];
      if (rx_rcv && r_state == S_CNT_L) r_count <= w_count;
      if (rx_rcv && r_state == S_DAT_H) r_hi <= rx_data[3:0];
      if (rx_rcv && (r_state == S_DAT_H || r_state == S_DAT_L)) r_sum <= r_sum + rx_data;
      if (rx_rcv && r_state == S_DAT_L) begin
        mem_addr <= r_idx;
        mem_din <= DW'({r_hi, rx_data});
      end
      if (r_state == S_WRITE) r_idx <= w_idx_inc;
    end
  end
endmodule

// File: tb/tb_simplez_loader.sv
// tb_simplez_loader: table-driven frame vectors plus hand sequences for backpressure, timeout and reset
module tb_simplez_loader;
  logic clk = 0, rstn = 0, rx_rcv = 0, tx_ready = 1;
  logic [7:0] rx_data = 0;
  logic tx_start, mem_we, cpu_rstn, busy;
  logic [7:0] tx_data;
  logic [8:0] mem_addr;
  logic [11:0] mem_din;
  int errors = 0, checks = 0, nwr = 0, ntx = 0;
  logic [7:0] last_tx = 0;
  logic [8:0] wa [64];
  logic [11:0] wd [64];
  typedef struct {
    logic [63:0] b;
    int n;
    logic [7:0] rsp;
    int nw;
    logic [11:0] w0, w1;
    logic cpu;
  } vec_t;
  vec_t v [6];
  always #5 clk = ~clk;
  simplez_loader #(.TIMEOUT(100)) dut (
    .clk(clk), .rstn(rstn), .rx_rcv(rx_rcv), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .cpu_rstn(cpu_rstn), .busy(busy)
  );
  always @(negedge clk) begin
    if (mem_we) begin
      if (nwr < 64) begin
        wa[nwr] = mem_addr;
        wd[nwr] = mem_din;
      end
      nwr++;
    end
    if (tx_start) begin
      ntx++;
      last_tx = tx_data;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_rcv = 1;
    @(posedge clk); #1 rx_rcv = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_din"}, mem_din, 0);
    chk({tag, "_cpu_rstn"}, cpu_rstn, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, t0, cyc;
    logic [63:0] fb;
    v[0] = '{64'h4C00020A0503FF11, 8, 8'h4B, 2, 12'hA05, 12'h3FF, 1'b1};
    v[1] = '{64'h4C00020A0503FF12, 8, 8'h45, 2, 12'hA05, 12'h3FF, 1'b0};
    v[2] = '{64'h4C01F90000000000, 3, 8'h45, 0, 12'h000, 12'h000, 1'b0};
    v[3] = '{64'h4C00000000000000, 3, 8'h45, 0, 12'h000, 12'h000, 1'b0};
    v[4] = '{64'h4C0001F7FFF60000, 6, 8'h4B, 1, 12'h7FF, 12'h000, 1'b1};
    v[5] = '{64'h4CFE020A0503FF11, 8, 8'h4B, 2, 12'hA05, 12'h3FF, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1;
    send(8'h00);
    chk("noise00_busy", busy, 0);
    send(8'h41);
    chk("noise41_busy", busy, 0);
    chk("noise_cpu_rstn", cpu_rstn, 1);
    chk("noise_writes", nwr, 0);
    chk("noise_tx", ntx, 0);
    for (int i = 0; i < 6; i++) begin
      w0 = nwr;
      t0 = ntx;
      fb = v[i].b;
      for (int k = 0; k < v[i].n; k++) send(fb[63-8*k -: 8]);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("v%0d_writes", i), nwr - w0, v[i].nw);
      if (v[i].nw > 0) begin
        chk($sformatf("v%0d_addr0", i), wa[w0], 0);
        chk($sformatf("v%0d_data0", i), wd[w0], v[i].w0);
      end
      if (v[i].nw > 1) begin
        chk($sformatf("v%0d_addr1", i), wa[w0+1], 1);
        chk($sformatf("v%0d_data1", i), wd[w0+1], v[i].w1);
      end
      chk($sformatf("v%0d_tx_count", i), ntx - t0, 1);
      chk($sformatf("v%0d_tx_data", i), last_tx, v[i].rsp);
      chk($sformatf("v%0d_cpu_rstn", i), cpu_rstn, v[i].cpu);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end
    tx_ready = 0;
    t0 = ntx;
    fb = v[0].b;
    for (int k = 0; k < 8; k++) send(fb[63-8*k -: 8]);
    repeat (50) @(posedge clk);
    #1;
    chk("bp_no_tx_yet", ntx - t0, 0);
    chk("bp_busy", busy, 1);
    chk("bp_cpu_held", cpu_rstn, 0);
    tx_ready = 1;
    @(negedge clk);
    chk("bp_start_not_early", tx_start, 0);
    @(negedge clk);
    chk("bp_start", tx_start, 1);
    chk("bp_tx_data", tx_data, 8'h4B);
    chk("bp_cpu_still_low", cpu_rstn, 0);
    @(negedge clk);
    chk("bp_start_drop", tx_start, 0);
    chk("bp_cpu_release", cpu_rstn, 1);
    chk("bp_idle", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_single_pulse", ntx - t0, 1);
    send(8'h4C);
    send(8'h00);
    send(8'h01);
    send(8'h0A);
    t0 = ntx;
    cyc = 0;
    while (ntx == t0 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("to_fired", ntx - t0, 1);
    chk("to_rsp", last_tx, 8'h45);
    chk("to_delay_in_range", (cyc >= 90 && cyc <= 110), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("to_busy", busy, 0);
    chk("to_cpu_held", cpu_rstn, 0);
    send(8'h4C);
    send(8'h00);
    send(8'h02);
    send(8'h0A);
    rstn = 0;
    @(posedge clk);
    #1 rstn = 1;
    chk_reset_outputs("midload");
    w0 = nwr;
    t0 = ntx;
    rx_data = 8'h4C;
    rx_rcv = 1;
    @(posedge clk); #1 rx_rcv = 0;
    @(negedge clk);
    chk("reload_cpu_low", cpu_rstn, 0);
    chk("reload_busy", busy, 1);
    @(posedge clk); #1;
    send(8'h00);
    send(8'h02);
    send(8'h0A);
    send(8'h05);
    send(8'h03);
    rx_data = 8'hFF;
    rx_rcv = 1;
    @(posedge clk); #1 rx_rcv = 0;
    @(negedge clk);
    chk("reload_we", mem_we, 1);
    chk("reload_addr", mem_addr, 1);
    chk("reload_din", mem_din, 12'h3FF);
    @(negedge clk);
    chk("reload_we_one_cycle", mem_we, 0);
    @(posedge clk); #1;
    send(8'h11);
    repeat (4) @(posedge clk);
    #1;
    chk("reload_writes", nwr - w0, 2);
    chk("reload_data0", wd[w0], 12'hA05);
    chk("reload_tx_count", ntx - t0, 1);
    chk("reload_rsp", last_tx, 8'h4B);
    chk("reload_cpu_run", cpu_rstn, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
